// File: rtl/data_launch_pkg.sv
// Shared definitions for data_launch: FSM state encoding, default parameters
// and the hold/gap counter width helper.
package data_launch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 4;

  // The counter is loaded with (cycles-1), so it must hold max(hold,gap)-1.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/launch_fifo.sv
// Source-side buffer for data_launch: power-of-two circular FIFO with
// occupancy count; pushes are refused while full even if a pop occurs.
module launch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_valid && !full;
  assign pop     = rd && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_launch.sv
// Launches buffered words onto a registered bus with an enable pulse of
// HOLD_CYCLES followed by GAP_CYCLES of settle time. Optional sticky overflow
// flag via DATA_LAUNCH_OVERFLOW_EN.
module data_launch
  import data_launch_pkg::*;
#(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [BUS_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
`ifdef DATA_LAUNCH_OVERFLOW_EN
  output logic                         overflow,
`endif
  output state_t                       fsm_state
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  logic [BUS_WIDTH-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic [CNT_W-1:0]     cnt;
  state_t               state;

  // Valid/ready: a word transfers on a rising CLK edge where in_valid && in_ready.
  assign in_ready  = !full;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign fsm_state = state;

  launch_fifo #(
    .W     (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .wr_data  (in_data),
    .wr_valid (in_valid),
    .rd       (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            unsync_bus <= head;
            bus_enable <= 1'b1;
            cnt        <= CNT_W'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus_enable <= 1'b0;
            cnt        <= CNT_W'(GAP_CYCLES - 1);
            state      <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          // The bus keeps its word through the gap so the far side samples a stable value.
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_LAUNCH_OVERFLOW_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  overflow <= 1'b0;
    else if (in_valid && full) overflow <= 1'b1;
  end
`endif

endmodule
